// File: rtl/pwm_counter.sv
// Prescaled up/down PWM time-base counter with shadowed period/prescale
// registers that only reload on count_reset, enable rise and wrap events.
module pwm_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        count_reset,
  input  logic        upnotdown,
  input  logic [15:0] period,
  input  logic [7:0]  prescale,
  output logic [15:0] count_val,
  output logic        ovf,
  output logic        udf
);

  logic        en_q, en_d;
  logic [7:0]  psc_cnt_q, psc_cnt_d;
  logic [7:0]  psc_act_q, psc_act_d;
  logic [15:0] per_act_q, per_act_d;
  logic [15:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  logic        en_rise;
  logic [7:0]  psc_eff;
  logic [15:0] per_eff;
  logic        tick;

  // On an enable rise the freshly sampled values take effect in that same cycle.
  assign en_rise = en & ~en_q;
  assign psc_eff = en_rise ? prescale : psc_act_q;
  assign per_eff = en_rise ? period   : per_act_q;
  assign tick    = (psc_cnt_q >= psc_eff);

  always_comb begin
    en_d      = en;
    psc_cnt_d = psc_cnt_q;
    psc_act_d = psc_act_q;
    per_act_d = per_act_q;
    count_d   = count_q;
    ovf_d     = 1'b0;
    udf_d     = 1'b0;

    if (count_reset) begin
      psc_cnt_d = 8'd0;
      count_d   = upnotdown ? 16'd0 : period;
      per_act_d = period;
      psc_act_d = prescale;
    end else if (!en) begin
      psc_cnt_d = 8'd0;
    end else begin
      if (en_rise) begin
        per_act_d = period;
        psc_act_d = prescale;
      end
      if (tick) begin
        psc_cnt_d = 8'd0;
        if (upnotdown) begin
          // >= so a count stranded above a lowered period wraps on the next tick
          if (count_q >= per_eff) begin
            count_d   = 16'd0;
            ovf_d     = 1'b1;
            per_act_d = period;
            psc_act_d = prescale;
          end else begin
            count_d = count_q + 16'd1;
          end
        end else begin
          if (count_q == 16'd0) begin
            count_d   = period;
            udf_d     = 1'b1;
            per_act_d = period;
            psc_act_d = prescale;
          end else begin
            count_d = count_q - 16'd1;
          end
        end
      end else begin
        psc_cnt_d = psc_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      psc_cnt_q <= 8'd0;
      psc_act_q <= 8'd0;
      per_act_q <= 16'd0;
      count_q   <= 16'd0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      psc_cnt_q <= psc_cnt_d;
      psc_act_q <= psc_act_d;
      per_act_q <= per_act_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign count_val = count_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Scoreboard bench for pwm_counter: directed per-cycle vectors push expected
// outputs, a monitor pops one entry after every rising edge and compares.
module tb_pwm_counter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        count_reset;
  logic        upnotdown;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic [15:0] count_val;
  logic        ovf;
  logic        udf;

  typedef struct {
    logic [15:0] cnt;
    logic        o;
    logic        u;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  pwm_counter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .count_reset (count_reset),
    .upnotdown   (upnotdown),
    .period      (period),
    .prescale    (prescale),
    .count_val   (count_val),
    .ovf         (ovf),
    .udf         (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec%0d: actual=%0d required=%0d", name, id, act, req);
    end
  endtask

  // Monitor: every rising edge presents one output sample.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count_val", e.id, count_val, e.cnt);
      chk("ovf", e.id, {15'd0, ovf}, {15'd0, e.o});
      chk("udf", e.id, {15'd0, udf}, {15'd0, e.u});
    end
  end

  task automatic step(input logic e_i, input logic cr_i, input logic up_i,
                      input logic [15:0] per_i, input logic [7:0] psc_i,
                      input logic [15:0] x_cnt, input logic x_o, input logic x_u);
    exp_t e;
    @(negedge clk);
    en          = e_i;
    count_reset = cr_i;
    upnotdown   = up_i;
    period      = per_i;
    prescale    = psc_i;
    vec_id++;
    e.cnt = x_cnt; e.o = x_o; e.u = x_u; e.id = vec_id;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; en = 1'b0; count_reset = 1'b0; upnotdown = 1'b1;
    period = 16'd0; prescale = 8'd0;
    #12;
    chk("reset_cnt", 0, count_val, 16'd0);
    chk("reset_ovf", 0, {15'd0, ovf}, 16'd0);
    chk("reset_udf", 0, {15'd0, udf}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up count, period 3, no prescale
    step(1,0,1,3,0, 1,0,0);
    step(1,0,1,3,0, 2,0,0);
    step(1,0,1,3,0, 3,0,0);
    step(1,0,1,3,0, 0,1,0);
    step(1,0,1,3,0, 1,0,0);
    step(1,0,1,3,0, 2,0,0);
    step(0,0,1,3,0, 2,0,0);
    step(0,1,1,3,0, 0,0,0);

    // Prescale 2: every value held three cycles
    step(1,0,1,2,2, 0,0,0);
    step(1,0,1,2,2, 0,0,0);
    step(1,0,1,2,2, 1,0,0);
    step(1,0,1,2,2, 1,0,0);
    step(1,0,1,2,2, 1,0,0);
    step(1,0,1,2,2, 2,0,0);
    step(1,0,1,2,2, 2,0,0);
    step(1,0,1,2,2, 2,0,0);
    step(1,0,1,2,2, 0,1,0);
    step(1,0,1,2,2, 0,0,0);
    step(1,0,1,2,2, 0,0,0);
    step(1,0,1,2,2, 1,0,0);
    step(1,1,1,2,2, 0,0,0);
    step(0,0,1,2,2, 0,0,0);

    // Down count from count_reset, period 4
    step(0,1,0,4,0, 4,0,0);
    step(1,0,0,4,0, 3,0,0);
    step(1,0,0,4,0, 2,0,0);
    step(1,0,0,4,0, 1,0,0);
    step(1,0,0,4,0, 0,0,0);
    step(1,0,0,4,0, 4,0,1);
    step(1,0,0,4,0, 3,0,0);
    step(0,0,0,4,0, 3,0,0);

    // Direction change mid-count: no jump, no pulse
    step(1,0,1,4,0, 4,0,0);
    step(1,0,0,4,0, 3,0,0);
    step(1,0,1,4,0, 4,0,0);
    step(1,0,1,4,0, 0,1,0);
    step(0,0,1,4,0, 0,0,0);

    // Shadow: period lowered to 2 while counting to 5
    step(1,0,1,5,0, 1,0,0);
    step(1,0,1,2,0, 2,0,0);
    step(1,0,1,2,0, 3,0,0);
    step(1,0,1,2,0, 4,0,0);
    step(1,0,1,2,0, 5,0,0);
    step(1,0,1,2,0, 0,1,0);
    step(1,0,1,2,0, 1,0,0);
    step(1,0,1,2,0, 2,0,0);
    step(1,0,1,2,0, 0,1,0);
    step(1,0,1,2,0, 1,0,0);
    step(1,0,1,2,0, 2,0,0);

    // Hold with en low, then resume after psc_act+1 cycles
    for (int i = 0; i < 10; i++) step(0,0,1,2,0, 2,0,0);
    step(1,0,1,5,1, 2,0,0);
    step(1,0,1,5,1, 3,0,0);
    step(1,0,1,5,1, 3,0,0);
    step(1,0,1,5,1, 4,0,0);

    // Asynchronous reset mid-count
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cnt", vec_id, count_val, 16'd0);
    chk("async_ovf", vec_id, {15'd0, ovf}, 16'd0);
    chk("async_udf", vec_id, {15'd0, udf}, 16'd0);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vec_id++;
    e.cnt = 16'd0; e.o = 1'b0; e.u = 1'b0; e.id = vec_id;
    exp_q.push_back(e);
    step(1,0,1,5,1, 0,0,0);
    step(1,0,1,5,1, 1,0,0);

    // Zero period: wrap pulse every tick, count pinned at 0
    step(1,1,1,0,1, 0,0,0);
    step(1,0,1,0,1, 0,0,0);
    step(1,0,1,0,1, 0,1,0);
    step(1,0,1,0,1, 0,0,0);
    step(1,0,1,0,1, 0,1,0);
    step(1,1,0,0,1, 0,0,0);
    step(1,0,0,0,1, 0,0,0);
    step(1,0,0,0,1, 0,0,1);
    step(1,0,0,0,1, 0,0,0);
    step(1,0,0,0,1, 0,0,1);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
